// File: rtl/pdm_demod.sv
// pdm_demod: decimating PDM-to-PCM demodulator.
//
// Counts the ones in consecutive, back-to-back windows of 2^DECIM_LOG2 accepted
// PDM bits. At the end of each window the count is rescaled to OUT_W bits,
// saturated, and presented as a PCM sample one clock after the final bit.
//
// Parameters
//   DECIM_LOG2  log2 of the window length in accepted bits (1..16)
//   OUT_W       output sample width (2..16)
//
// Ports
//   clk         clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   en          input-bit strobe; din is accepted only when en=1
//   din         PDM bit stream
//   dout        most recent PCM sample, held between updates
//   dout_valid  one-cycle pulse with each dout update
//   locked      high once the first window after reset has been delivered
//   clip        high in the dout_valid cycle when the sample was saturated

module pdm_demod #(
    parameter int unsigned DECIM_LOG2 = 10,
    parameter int unsigned OUT_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             locked,
    output logic             clip
);

    // The scaled value is wide enough for the largest left shift of the
    // largest count, so saturation is a simple test of the upper bits.
    localparam int unsigned SW  = DECIM_LOG2 + OUT_W + 1;
    localparam int unsigned SHR = (DECIM_LOG2 >= OUT_W) ? (DECIM_LOG2 - OUT_W) : 0;
    localparam int unsigned SHL = (DECIM_LOG2 >= OUT_W) ? 0 : (OUT_W - DECIM_LOG2);

    typedef enum logic [0:0] {
        StFill,
        StRun
    } state_e;

    state_e                state_q;
    logic [DECIM_LOG2-1:0] cnt_q;
    logic [DECIM_LOG2:0]   acc_q;

    logic                  win_done;
    logic [DECIM_LOG2:0]   c;
    logic [SW-1:0]         scaled;
    logic                  sat;
    logic [OUT_W-1:0]      sample;

    always_comb begin
        win_done = en && (&cnt_q);
        // Count including the bit accepted this cycle.
        c        = acc_q + {{DECIM_LOG2{1'b0}}, din};
        scaled   = (SW'(c) >> SHR) << SHL;
        sat      = |scaled[SW-1:OUT_W];
        sample   = sat ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            cnt_q      <= '0;
            acc_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            locked     <= 1'b0;
            clip       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            clip       <= 1'b0;
            if (en) begin
                if (win_done) begin
                    cnt_q      <= '0;
                    acc_q      <= '0;
                    dout       <= sample;
                    dout_valid <= 1'b1;
                    clip       <= sat;
                    unique case (state_q)
                        StFill: begin
                            state_q <= StRun;
                            locked  <= 1'b1;
                        end
                        StRun: begin
                            state_q <= StRun;
                            locked  <= 1'b1;
                        end
                        default: begin
                            state_q <= StRun;
                            locked  <= 1'b1;
                        end
                    endcase
                end else begin
                    cnt_q <= cnt_q + DECIM_LOG2'(1);
                    acc_q <= c;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_demod.sv
// Bench for pdm_demod: two instances (DECIM_LOG2=10 and 8, OUT_W=10) share
// stimulus. A window-counting model checks every output on every negedge;
// directed literal checks pin the model at known points.

module tb_pdm_demod;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic din = 1'b0;

    logic [9:0] dout_a, dout_b;
    logic       valid_a, valid_b, locked_a, locked_b, clip_a, clip_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pdm_demod #(.DECIM_LOG2(10), .OUT_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .dout(dout_a), .dout_valid(valid_a), .locked(locked_a), .clip(clip_a)
    );

    pdm_demod #(.DECIM_LOG2(8), .OUT_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .dout(dout_b), .dout_valid(valid_b), .locked(locked_b), .clip(clip_b)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic smp_ok = 1'b0, smp_en = 1'b0, smp_din = 1'b0;
    always @(posedge clk) begin
        smp_ok  <= rst_n;
        smp_en  <= en;
        smp_din <= din;
    end

    int win   [2] = '{1024, 256};
    int m_cnt [2] = '{0, 0};
    int m_one [2] = '{0, 0};
    int m_dout[2] = '{0, 0};
    int m_lock[2] = '{0, 0};
    int m_val [2] = '{0, 0};
    int m_clip[2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_val[i]  = 0;
            m_clip[i] = 0;
            if (!rst_n) begin
                m_cnt[i] = 0; m_one[i] = 0; m_dout[i] = 0; m_lock[i] = 0;
            end else if (smp_ok && smp_en) begin
                m_cnt[i] += 1;
                m_one[i] += int'(smp_din);
                if (m_cnt[i] == win[i]) begin
                    // Full-scale count maps to 2^OUT_W, then saturate.
                    int raw;
                    raw = m_one[i] * 1024 / win[i];
                    m_val[i]  = 1;
                    m_clip[i] = (raw > 1023) ? 1 : 0;
                    m_dout[i] = (raw > 1023) ? 1023 : raw;
                    m_lock[i] = 1;
                    m_cnt[i]  = 0;
                    m_one[i]  = 0;
                end
            end
        end
        check("a.dout",   int'(dout_a),   m_dout[0]);
        check("a.valid",  int'(valid_a),  m_val[0]);
        check("a.locked", int'(locked_a), m_lock[0]);
        check("a.clip",   int'(clip_a),   m_clip[0]);
        check("b.dout",   int'(dout_b),   m_dout[1]);
        check("b.valid",  int'(valid_b),  m_val[1]);
        check("b.locked", int'(locked_b), m_lock[1]);
        check("b.clip",   int'(clip_b),   m_clip[1]);
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; leaves the bench at the following posedge+1.
    task automatic drive(input logic e, input logic d);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    int sd_acc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.dout", int'(dout_a), 0);
        check("rst.locked", int'(locked_a), 0);
        rst_n = 1'b1;

        // All ones: full scale saturates on both instances.
        for (int i = 0; i < 1024; i++) drive(1'b1, 1'b1);
        check("ones.a.dout", int'(dout_a), 1023);
        check("ones.a.valid", int'(valid_a), 1);
        check("ones.a.clip", int'(clip_a), 1);
        check("ones.a.locked", int'(locked_a), 1);
        check("ones.b.dout", int'(dout_b), 1023);
        check("ones.b.clip", int'(clip_b), 1);

        drive(1'b0, 1'b1);
        check("idle.a.valid", int'(valid_a), 0);
        check("idle.a.dout", int'(dout_a), 1023);

        // Alternating bits: half scale.
        for (int i = 0; i < 1024; i++) drive(1'b1, (i % 2) == 0);
        check("alt.a.dout", int'(dout_a), 512);
        check("alt.a.clip", int'(clip_a), 0);
        check("alt.b.dout", int'(dout_b), 512);
        check("alt.b.clip", int'(clip_b), 0);

        for (int i = 0; i < 1024; i++) drive(1'b1, 1'b0);
        check("zero.a.dout", int'(dout_a), 0);
        check("zero.a.valid", int'(valid_a), 1);

        // Strobe every other cycle: window spans 2048 clocks.
        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, 1'b1);
            if (i == 1023) begin
                check("half.a.valid", int'(valid_a), 1);
                check("half.a.dout", int'(dout_a), 1023);
            end else if (i == 511) begin
                check("half.a.hold", int'(dout_a), 0);
                check("half.a.novalid", int'(valid_a), 0);
            end
            drive(1'b0, 1'b1);
            if (i == 1023) check("half.a.after", int'(valid_a), 0);
        end

        // Partial window discarded by a reset pulse.
        for (int i = 0; i < 500; i++) drive(1'b1, 1'b1);
        en    = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst.a.dout", int'(dout_a), 0);
        check("midrst.a.locked", int'(locked_a), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) drive(1'b1, (i % 2) == 0);
        check("postrst.a.dout", int'(dout_a), 512);
        check("postrst.a.locked", int'(locked_a), 1);

        // First-order sigma-delta modulator loopback at level 300/1024.
        sd_acc = 0;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 1024; i++) begin
                sd_acc += 300;
                if (sd_acc >= 1024) begin
                    sd_acc -= 1024;
                    drive(1'b1, 1'b1);
                end else begin
                    drive(1'b1, 1'b0);
                end
            end
            check("loop.a.inrange", int'(dout_a >= 10'd299 && dout_a <= 10'd301), 1);
        end

        drive(1'b0, 1'b0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pdm_demod.md
PDM_DEMOD -- requirements
Module: pdm_demod

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 10: the window is 2^DECIM_LOG2 accepted input bits; legal range 1..16.
REQ-002 SHALL have parameter OUT_W, default 10: output sample width; legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: input-bit strobe; din is accepted in a cycle only when en=1.
REQ-006 SHALL have port din, input, 1 bit: PDM bit stream, first-order density encoding as produced by the team's pdm modulator.
REQ-007 SHALL have port dout, output, OUT_W bits: most recent decimated PCM sample, held between updates.
REQ-008 SHALL have port dout_valid, output, 1 bit: one-cycle pulse, coincident with each dout update.
REQ-009 SHALL have port locked, output, 1 bit: high once the first complete window after reset has been delivered.
REQ-010 SHALL have port clip, output, 1 bit: high in the dout_valid cycle when the delivered sample was saturated, else low.

Function
REQ-011 SHALL implement a two-state FSM: FILL (reset state; no sample delivered yet) and RUN; FILL->RUN on the first window completion, RUN is absorbing until reset.
REQ-012 SHALL keep a sample counter cnt (DECIM_LOG2 bits) and a ones accumulator acc (DECIM_LOG2+1 bits); each accepted bit increments cnt and adds din to acc.
REQ-013 SHALL, when en=0, hold cnt, acc, dout, locked and FSM state, and drive dout_valid=0 and clip=0.
REQ-014 SHALL complete a window on the accepted cycle with cnt=2^DECIM_LOG2-1, forming c = acc + din, range 0..2^DECIM_LOG2.
REQ-015 SHALL scale c as follows: if DECIM_LOG2>=OUT_W, c >> (DECIM_LOG2-OUT_W); otherwise c << (OUT_W-DECIM_LOG2); either result saturates to 2^OUT_W-1.
REQ-016 SHALL, on the clock edge ending the completing cycle, register the scaled value into dout, assert dout_valid and clip (clip = saturation occurred) for exactly one cycle, and set locked=1.
REQ-017 SHALL, in that same edge, clear cnt to 0 and load acc with 0; no input bit is lost or double-counted across windows.
REQ-018 SHALL give a latency of one clock from the final accepted bit of a window to dout/dout_valid.
REQ-019 SHALL count cnt with wrap-around modulo 2^DECIM_LOG2; windows are back-to-back with no gap cycles.
REQ-020 SHALL NOT let dout_valid pulse in two consecutive cycles unless DECIM_LOG2 windows complete on consecutive cycles, which is impossible for DECIM_LOG2>=1.

Reset
REQ-021 SHALL, while rst_n=0, force dout=0, dout_valid=0, locked=0, clip=0, cnt=0, acc=0 and FSM=FILL, regardless of clk.
REQ-022 SHALL, on rst_n asserted mid-window, discard the partial window; the first window after release starts with the first accepted bit following release.

Verification (DECIM_LOG2=10, OUT_W=10 unless stated)
REQ-023 SHALL be verified with en=1 and din=1 for 1024 cycles -> one cycle later: dout=1023, dout_valid=1, clip=1, locked=1.
REQ-024 SHALL be verified with en=1 and din alternating 1,0 for 1024 cycles -> dout=512, clip=0; then din=0 for 1024 cycles -> dout=0.
REQ-025 SHALL be verified with en high every other cycle and din=1 -> dout_valid only after 2048 clocks; dout held and dout_valid=0 while en=0.
REQ-026 SHALL be verified by feeding 500 ones, pulsing rst_n low, then 1024 alternating bits -> dout=0/locked=0 during reset, and the next dout=512 with the stale ones not counted.
REQ-027 SHALL be verified by driving the team's pdm modulator with din=300 in loopback -> every dout after the first window is within 299..301.
REQ-028 SHALL be verified with DECIM_LOG2=8 -> 256 ones give dout=1023 and clip=1; 128 ones in a window give dout=512 and clip=0.
